// File: rtl/vector_shifter_pkg.sv
// Shared types for the multi-lane vector shifter: shift modes and control states.
package shifter_pkg;

   typedef enum logic [1:0] {
      SLL = 2'b00,
      SRL = 2'b01,
      SRA = 2'b10,
      ROR = 2'b11
   } shift_mode_t;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      BUSY = 2'b01,
      DONE = 2'b10
   } shift_state_t;

endpackage

// File: rtl/vector_shifter_lane_step.sv
// One lane, one clock's worth of shifting: moves a WIDTH-bit value by 0..STEP positions.
module shift_lane_step
   import shifter_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int STEP  = 1
) (
   input  logic [WIDTH-1:0]             value,
   input  logic [1:0]                   mode,
   input  logic [$clog2(STEP+1)-1:0]    amt,
   output logic [WIDTH-1:0]             result
);

   logic signed [WIDTH-1:0] value_s;
   logic [2*WIDTH-1:0]      ror_ext;

   assign value_s = value;
   // Rotation falls out of shifting a doubled copy; the low half is the rotated lane.
   assign ror_ext = {value, value} >> amt;

   always_comb begin
      result = value;
      case (shift_mode_t'(mode))
         SLL:     result = value << amt;
         SRL:     result = value >> amt;
         SRA:     result = value_s >>> amt;
         ROR:     result = ror_ext[WIDTH-1:0];
         default: result = value;
      endcase
   end

endmodule

// File: rtl/vector_shifter.sv
// Multi-cycle lane-parallel shifter with valid/ready on both sides; moves at most STEP bits per clock.
module vector_shifter #(
   parameter int WIDTH = 8,
   parameter int LANES = 4,
   parameter int STEP  = 1
) (
   input  logic                       CLK,
   input  logic                       RST_N,
   input  logic                       IN_VALID,
   output logic                       IN_READY,
   input  logic [LANES*WIDTH-1:0]     DATA,
   input  logic [1:0]                 MODE,
   input  logic [$clog2(WIDTH)-1:0]   SHAMT,
   output logic                       OUT_VALID,
   input  logic                       OUT_READY,
   output logic [LANES*WIDTH-1:0]     SHIFTED,
   output logic                       BUSY
);
   import shifter_pkg::*;

   localparam int SW = $clog2(WIDTH);
   localparam int AW = $clog2(STEP+1);

   shifter_pkg::shift_state_t state;
   shift_mode_t               mode_q;
   logic [SW-1:0]             remaining;
   logic [SW-1:0]             step_k;
   logic [AW-1:0]             step_amt;
   logic [LANES*WIDTH-1:0]    work;
   logic [LANES*WIDTH-1:0]    next_work;

   // The final step may be shorter than STEP so the total lands exactly on SHAMT.
   assign step_k   = (remaining < SW'(STEP)) ? remaining : SW'(STEP);
   assign step_amt = AW'(step_k);

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      shift_lane_step #(
         .WIDTH (WIDTH),
         .STEP  (STEP)
      ) u_step (
         .value  (work[i*WIDTH +: WIDTH]),
         .mode   (mode_q),
         .amt    (step_amt),
         .result (next_work[i*WIDTH +: WIDTH])
      );
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state     <= shifter_pkg::IDLE;
         mode_q    <= SLL;
         remaining <= '0;
         work      <= '0;
      end else begin
         case (state)
            shifter_pkg::IDLE: begin
               if (IN_VALID) begin
                  work      <= DATA;
                  mode_q    <= shift_mode_t'(MODE);
                  remaining <= SHAMT;
                  state     <= (SHAMT == '0) ? shifter_pkg::DONE : shifter_pkg::BUSY;
               end
            end
            shifter_pkg::BUSY: begin
               work      <= next_work;
               remaining <= remaining - step_k;
               if (remaining == step_k) state <= shifter_pkg::DONE;
            end
            shifter_pkg::DONE: begin
               if (OUT_READY) state <= shifter_pkg::IDLE;
            end
            default: state <= shifter_pkg::IDLE;
         endcase
      end
   end

   assign IN_READY  = (state == shifter_pkg::IDLE);
   assign BUSY      = (state == shifter_pkg::BUSY);
   assign OUT_VALID = (state == shifter_pkg::DONE);
   assign SHIFTED   = work;

endmodule

// File: tb/tb_vector_shifter.sv
// Bench for vector_shifter: STEP=1 and STEP=4 instances share stimulus and are checked every cycle against a transaction model.
module tb_vector_shifter;

   logic        CLK = 1'b0;
   logic        RST_N, IN_VALID, OUT_READY;
   logic [31:0] DATA;
   logic [1:0]  MODE;
   logic [2:0]  SHAMT;

   logic [1:0]        in_ready, out_valid, busy;
   logic [1:0][31:0]  shifted;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 CLK = ~CLK;

   vector_shifter #(.WIDTH(8), .LANES(4), .STEP(1)) dut_s1 (
      .CLK(CLK), .RST_N(RST_N), .IN_VALID(IN_VALID), .IN_READY(in_ready[0]),
      .DATA(DATA), .MODE(MODE), .SHAMT(SHAMT), .OUT_VALID(out_valid[0]),
      .OUT_READY(OUT_READY), .SHIFTED(shifted[0]), .BUSY(busy[0])
   );

   vector_shifter #(.WIDTH(8), .LANES(4), .STEP(4)) dut_s4 (
      .CLK(CLK), .RST_N(RST_N), .IN_VALID(IN_VALID), .IN_READY(in_ready[1]),
      .DATA(DATA), .MODE(MODE), .SHAMT(SHAMT), .OUT_VALID(out_valid[1]),
      .OUT_READY(OUT_READY), .SHIFTED(shifted[1]), .BUSY(busy[1])
   );

   task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s dut%0d: got %h required %h at %0t", nm, d, act, exp, $time);
      end
   endtask

   function automatic int step_of(input int d);
      return (d == 0) ? 1 : 4;
   endfunction

   // Whole-amount shift of every lane, straight from the fill rules.
   function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic [1:0] m, input int s);
      logic [31:0] o;
      logic [7:0]  v, r;
      o = '0;
      for (int i = 0; i < 4; i++) begin
         v = d[i*8 +: 8];
         case (m)
            2'b00:   r = v << s;
            2'b01:   r = v >> s;
            2'b10:   r = v[7] ? ~((~v) >> s) : (v >> s);
            default: r = (s == 0) ? v : ((v >> s) | (v << (8 - s)));
         endcase
         o[i*8 +: 8] = r;
      end
      return o;
   endfunction

   // Transaction model: 0 = waiting for request, 1 = shifting, 2 = result held.
   int          ph[2];
   int          cnt[2];
   logic [31:0] mres[2];
   bit          zk[2];
   bit          armed = 1'b0;

   always @(posedge CLK) begin
      for (int d = 0; d < 2; d++) begin
         if (!RST_N) begin
            ph[d] = 0; cnt[d] = 0; mres[d] = '0; zk[d] = 1'b1;
         end else begin
            case (ph[d])
               0: if (IN_VALID) begin
                  mres[d] = ref_shift(DATA, MODE, int'(SHAMT));
                  zk[d]   = 1'b0;
                  cnt[d]  = (int'(SHAMT) + step_of(d) - 1) / step_of(d);
                  ph[d]   = (cnt[d] == 0) ? 2 : 1;
               end
               1: begin
                  cnt[d]--;
                  if (cnt[d] == 0) ph[d] = 2;
               end
               default: if (OUT_READY) ph[d] = 0;
            endcase
         end
      end
      if (!RST_N) armed = 1'b1;
   end

   always @(negedge CLK) begin
      if (armed) begin
         for (int d = 0; d < 2; d++) begin
            chk("in_ready",  d, 32'(in_ready[d]),  32'(ph[d] == 0));
            chk("busy",      d, 32'(busy[d]),      32'(ph[d] == 1));
            chk("out_valid", d, 32'(out_valid[d]), 32'(ph[d] == 2));
            if (ph[d] == 2 || zk[d]) chk("shifted", d, shifted[d], zk[d] ? 32'h0 : mres[d]);
         end
      end
   end

   task automatic tick;
      @(posedge CLK);
      #2;
   endtask

   task automatic wait_idle;
      int g;
      g = 0;
      while (in_ready != 2'b11 && g < 50) begin tick; g++; end
      chk("idle_wait", 0, 32'(g < 50), 32'd1);
   endtask

   task automatic run_dir(input logic [31:0] dat, input logic [1:0] m, input logic [2:0] s,
                          input logic [31:0] e, input int l1, input int l4);
      int got[2];
      int bc[2];
      logic [31:0] res[2];
      int k;
      wait_idle;
      DATA = dat; MODE = m; SHAMT = s; IN_VALID = 1'b1; OUT_READY = 1'b1;
      tick;
      IN_VALID = 1'b0; DATA = $urandom; MODE = 2'($urandom_range(3)); SHAMT = 3'($urandom_range(7));
      got = '{-1, -1}; bc = '{0, 0}; res = '{32'h0, 32'h0}; k = 0;
      while ((got[0] < 0 || got[1] < 0) && k < 40) begin
         @(negedge CLK);
         for (int i = 0; i < 2; i++) begin
            if (got[i] < 0) begin
               if (out_valid[i]) begin got[i] = k; res[i] = shifted[i]; end
               else if (busy[i]) bc[i]++;
            end
         end
         k++;
      end
      chk("dir_result",  0, res[0], e);
      chk("dir_result",  1, res[1], e);
      chk("dir_latency", 0, 32'(got[0]), 32'(l1));
      chk("dir_latency", 1, 32'(got[1]), 32'(l4));
      chk("dir_busy_cycles", 0, 32'(bc[0]), 32'(l1));
      chk("dir_busy_cycles", 1, 32'(bc[1]), 32'(l4));
      tick;
   endtask

   initial begin
      #1000000;
      $display("FAIL timeout: run did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int g;
      RST_N = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b1; DATA = '0; MODE = '0; SHAMT = '0;

      // Pin the model to hand-computed values.
      chk("model_sll", 0, ref_shift(32'h01020408, 2'b00, 3), 32'h08102040);
      chk("model_sra", 0, ref_shift(32'h80407F01, 2'b10, 7), 32'hFF000000);
      chk("model_ror", 0, ref_shift(32'h01800301, 2'b11, 1), 32'h80408180);
      chk("model_srl", 0, ref_shift(32'h01800301, 2'b01, 1), 32'h00400100);
      chk("model_zero", 0, ref_shift(32'hDEADBEEF, 2'b10, 0), 32'hDEADBEEF);

      repeat (2) tick;
      RST_N = 1'b1;
      tick;

      run_dir(32'h01020408, 2'b00, 3'd3, 32'h08102040, 3, 1);
      run_dir(32'h80407F01, 2'b10, 3'd7, 32'hFF000000, 7, 2);
      run_dir(32'h01800301, 2'b11, 3'd1, 32'h80408180, 1, 1);
      run_dir(32'h01800301, 2'b01, 3'd1, 32'h00400100, 1, 1);
      run_dir(32'hDEADBEEF, 2'b11, 3'd0, 32'hDEADBEEF, 0, 0);
      run_dir(32'hDEADBEEF, 2'b00, 3'd0, 32'hDEADBEEF, 0, 0);

      // Back-pressure with operands and a new request churning underneath.
      wait_idle;
      DATA = 32'h11223344; MODE = 2'b00; SHAMT = 3'd2; IN_VALID = 1'b1; OUT_READY = 1'b0;
      tick;
      IN_VALID = 1'b0;
      g = 0;
      while (out_valid != 2'b11 && g < 20) begin tick; g++; end
      chk("bp_reach_done", 0, 32'(g < 20), 32'd1);
      repeat (5) begin
         DATA = $urandom; MODE = 2'($urandom_range(3)); SHAMT = 3'($urandom_range(7)); IN_VALID = 1'b1;
         @(negedge CLK);
         chk("bp_hold", 0, shifted[0], 32'h4488CC10);
         chk("bp_hold", 1, shifted[1], 32'h4488CC10);
         chk("bp_in_ready", 0, 32'(in_ready), 32'd0);
         tick;
      end
      OUT_READY = 1'b1;
      tick;
      @(negedge CLK);
      chk("bp_release_in_ready", 0, 32'(in_ready), 32'h3);
      chk("bp_release_out_valid", 0, 32'(out_valid), 32'h0);
      IN_VALID = 1'b0;
      tick;

      // Reset on the third BUSY cycle of a 7-bit shift.
      wait_idle;
      DATA = 32'hC3A55A3C; MODE = 2'b00; SHAMT = 3'd7; IN_VALID = 1'b1; OUT_READY = 1'b1;
      tick;
      IN_VALID = 1'b0;
      tick;
      tick;
      @(negedge CLK);
      chk("rst_pre_busy", 0, 32'(busy[0]), 32'd1);
      RST_N = 1'b0; IN_VALID = 1'b1;
      tick;
      RST_N = 1'b1; IN_VALID = 1'b0;
      @(negedge CLK);
      chk("rst_in_ready", 0, 32'(in_ready), 32'h3);
      chk("rst_out_valid", 0, 32'(out_valid), 32'h0);
      chk("rst_busy", 0, 32'(busy), 32'h0);
      chk("rst_shifted", 0, shifted[0], 32'h0);
      chk("rst_shifted", 1, shifted[1], 32'h0);
      tick;
      run_dir(32'hA5C30F81, 2'b01, 3'd5, 32'h05060004, 5, 2);

      // Random traffic, including occasional reset and back-pressure.
      repeat (500) begin
         tick;
         IN_VALID  = 1'($urandom_range(1));
         DATA      = $urandom;
         MODE      = 2'($urandom_range(3));
         SHAMT     = 3'($urandom_range(7));
         OUT_READY = ($urandom_range(3) != 0);
         RST_N     = ($urandom_range(39) != 0);
      end
      tick;
      RST_N = 1'b1; IN_VALID = 1'b0; OUT_READY = 1'b1;
      repeat (20) tick;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
